// File: rtl/ysyx_23060075_sram_axi_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060075_sram_axi_pkg
// Shared ISA/AXI definitions for the SRAM AXI4-Lite slave:
//   ISA_WIDTH, MEM_MASK_WIDTH   - data path and byte-strobe widths
//   AXI_RESP_*                  - 2-bit AXI response codes
//   r_state_e / w_state_e       - read and write FSM encodings
//   word_offset()               - byte address -> word offset from a base
// ----------------------------------------------------------------------------
package ysyx_23060075_sram_axi_pkg;

  localparam int ISA_WIDTH      = 32;
  localparam int MEM_MASK_WIDTH = ISA_WIDTH / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  // Word offset of a byte address relative to base. Addresses below base wrap
  // to huge offsets, so a single unsigned compare against the depth is enough
  // for the window check.
  function automatic logic [ISA_WIDTH-1:0] word_offset(
    input logic [ISA_WIDTH-1:0] addr,
    input logic [ISA_WIDTH-1:0] base
  );
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/ysyx_23060075_sram_axi_lfsr.sv
// ----------------------------------------------------------------------------
// ysyx_23060075_lfsr
// 8-bit Fibonacci LFSR, taps 8,6,5,4, advanced once per clock. Used to draw
// random response latencies when YSYX_23060075_SRAM_RAND_DELAY_EN is defined.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (loads SEED)
//   q      out current LFSR state
// ----------------------------------------------------------------------------
module ysyx_23060075_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  logic [7:0] q_reg;
  logic       feedback;

  // Taps 8,6,5,4 map to bits 7,5,4,3 of the shift register.
  assign feedback = q_reg[7] ^ q_reg[5] ^ q_reg[4] ^ q_reg[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= SEED;
    end else begin
      q_reg <= {q_reg[6:0], feedback};
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/ysyx_23060075_sram_axi.sv
// ----------------------------------------------------------------------------
// ysyx_23060075_sram_axi
// AXI4-Lite slave memory: word-addressed array with independent read and
// write FSMs and programmable response latency.
// Optional feature macro: YSYX_23060075_SRAM_RAND_DELAY_EN
//   defined   - wait counts come from an 8-bit LFSR (read: bits [3:0],
//               write: bits [7:4])
//   undefined - READ_LATENCY / WRITE_LATENCY are used, no LFSR
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   axi_ar{addr,valid,ready}       read address channel
//   axi_r{data,resp,valid,ready}   read data channel (resp code in [1:0])
//   axi_aw{addr,valid,ready}       write address channel
//   axi_w{data,strb,valid,ready}   write data channel
//   axi_b{resp,valid,ready}        write response channel (code in [1:0])
// All outputs are driven from registers only.
// ----------------------------------------------------------------------------
module ysyx_23060075_sram_axi
  import ysyx_23060075_sram_axi_pkg::*;
#(
  parameter logic [ISA_WIDTH-1:0] ADDR_BASE     = 32'h8000_0000,
  parameter int                   DEPTH         = 4096,
  parameter int                   READ_LATENCY  = 1,
  parameter int                   WRITE_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ISA_WIDTH-1:0]      axi_araddr,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  output logic [ISA_WIDTH-1:0]      axi_rdata,
  output logic [ISA_WIDTH-1:0]      axi_rresp,
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  input  logic [ISA_WIDTH-1:0]      axi_awaddr,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [ISA_WIDTH-1:0]      axi_wdata,
  input  logic [MEM_MASK_WIDTH-1:0] axi_wstrb,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  output logic [ISA_WIDTH-1:0]      axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready
);

  localparam int                   IDX_W   = $clog2(DEPTH);
  localparam logic [ISA_WIDTH-1:0] DEPTH_W = ISA_WIDTH'(DEPTH);

  // --------------------------------------------------------------------------
  // Wait-count source
  // --------------------------------------------------------------------------
  logic [7:0] rd_lat;
  logic [7:0] wr_lat;

`ifdef YSYX_23060075_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  ysyx_23060075_lfsr #(
    .SEED (8'hA5)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign rd_lat = {4'd0, lfsr_q[3:0]};
  assign wr_lat = {4'd0, lfsr_q[7:4]};
`else
  assign rd_lat = 8'(READ_LATENCY);
  assign wr_lat = 8'(WRITE_LATENCY);
`endif

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  r_state_e             r_state_reg, r_state_next;
  logic [7:0]           r_cnt_reg, r_cnt_next;
  logic [ISA_WIDTH-1:0] r_addr_reg, r_addr_next;
  logic                 rd_load;
  logic [ISA_WIDTH-1:0] rd_word_off;
  logic                 rd_ok;
  logic [IDX_W-1:0]     rd_idx;
  logic                 rd_ok_reg;
  logic [1:0]           rresp_reg;
  logic [ISA_WIDTH-1:0] rd_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_reg <= R_IDLE;
      r_cnt_reg   <= '0;
      r_addr_reg  <= '0;
      rd_ok_reg   <= 1'b0;
      rresp_reg   <= AXI_RESP_OKAY;
    end else begin
      r_state_reg <= r_state_next;
      r_cnt_reg   <= r_cnt_next;
      r_addr_reg  <= r_addr_next;
      if (rd_load) begin
        rd_ok_reg <= rd_ok;
        rresp_reg <= rd_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
      end
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    r_cnt_next   = r_cnt_reg;
    r_addr_next  = r_addr_reg;
    rd_load      = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        if (axi_arvalid) begin
          r_addr_next = axi_araddr;
          r_cnt_next  = rd_lat;
          if (rd_lat == 8'd0) begin
            r_state_next = R_RESP;
            rd_load      = 1'b1;
          end else begin
            r_state_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        r_cnt_next = r_cnt_reg - 8'd1;
        if (r_cnt_reg <= 8'd1) begin
          r_state_next = R_RESP;
          rd_load      = 1'b1;
        end
      end
      R_RESP: begin
        if (axi_rready) begin
          r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // r_addr_next is the incoming address on a zero-latency handshake and the
  // latched one otherwise, so the array is always read with the right index.
  assign rd_word_off = word_offset(r_addr_next, ADDR_BASE);
  assign rd_ok       = rd_word_off < DEPTH_W;
  assign rd_idx      = IDX_W'(rd_word_off);

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  w_state_e                  w_state_reg, w_state_next;
  logic [7:0]                w_cnt_reg, w_cnt_next;
  logic [ISA_WIDTH-1:0]      w_addr_reg, w_addr_next;
  logic [ISA_WIDTH-1:0]      w_data_reg, w_data_next;
  logic [MEM_MASK_WIDTH-1:0] w_strb_reg, w_strb_next;
  logic                      aw_got_reg, aw_got_next;
  logic                      w_got_reg, w_got_next;
  logic                      wr_commit;
  logic                      wr_en;
  logic [ISA_WIDTH-1:0]      wr_word_off;
  logic                      wr_ok;
  logic [IDX_W-1:0]          wr_idx;
  logic [1:0]                bresp_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg <= W_IDLE;
      w_cnt_reg   <= '0;
      w_addr_reg  <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      aw_got_reg  <= 1'b0;
      w_got_reg   <= 1'b0;
      bresp_reg   <= AXI_RESP_OKAY;
    end else begin
      w_state_reg <= w_state_next;
      w_cnt_reg   <= w_cnt_next;
      w_addr_reg  <= w_addr_next;
      w_data_reg  <= w_data_next;
      w_strb_reg  <= w_strb_next;
      aw_got_reg  <= aw_got_next;
      w_got_reg   <= w_got_next;
      if (wr_commit) begin
        bresp_reg <= wr_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
      end
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    w_cnt_next   = w_cnt_reg;
    w_addr_next  = w_addr_reg;
    w_data_next  = w_data_reg;
    w_strb_next  = w_strb_reg;
    aw_got_next  = aw_got_reg;
    w_got_next   = w_got_reg;
    wr_commit    = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (axi_awvalid && !aw_got_reg) begin
          w_addr_next = axi_awaddr;
          aw_got_next = 1'b1;
        end
        if (axi_wvalid && !w_got_reg) begin
          w_data_next = axi_wdata;
          w_strb_next = axi_wstrb;
          w_got_next  = 1'b1;
        end
        // Both halves captured (now or earlier): leave idle.
        if (aw_got_next && w_got_next) begin
          aw_got_next = 1'b0;
          w_got_next  = 1'b0;
          w_cnt_next  = wr_lat;
          if (wr_lat == 8'd0) begin
            w_state_next = W_RESP;
            wr_commit    = 1'b1;
          end else begin
            w_state_next = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        w_cnt_next = w_cnt_reg - 8'd1;
        if (w_cnt_reg <= 8'd1) begin
          w_state_next = W_RESP;
          wr_commit    = 1'b1;
        end
      end
      W_RESP: begin
        if (axi_bready) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  assign wr_word_off = word_offset(w_addr_next, ADDR_BASE);
  assign wr_ok       = wr_word_off < DEPTH_W;
  assign wr_idx      = IDX_W'(wr_word_off);
  // The array has no reset, so a commit must be blocked explicitly while
  // rst_n is low; otherwise a zero-latency write could land during reset.
  assign wr_en       = wr_commit && wr_ok && rst_n;

  // --------------------------------------------------------------------------
  // Storage: one byte-wide array per lane so each strobe is a plain write
  // enable. Registered read; on a same-cycle read/write to one index the
  // read returns the old byte.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < MEM_MASK_WIDTH; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_byte;

    always_ff @(posedge clk) begin
      if (wr_en && w_strb_next[gi]) begin
        mem[wr_idx] <= w_data_next[gi*8 +: 8];
      end
      if (rd_load && rd_ok) begin
        rd_byte <= mem[rd_idx];
      end
    end

    assign rd_raw[gi*8 +: 8] = rd_byte;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign axi_arready = (r_state_reg == R_IDLE);
  assign axi_rvalid  = (r_state_reg == R_RESP);
  // rd_ok_reg clears on reset and on an out-of-window read, so rdata reads 0
  // in both cases regardless of what the RAM output register holds.
  assign axi_rdata   = rd_ok_reg ? rd_raw : '0;
  assign axi_rresp   = {{(ISA_WIDTH-2){1'b0}}, rresp_reg};

  assign axi_awready = (w_state_reg == W_IDLE) && !aw_got_reg;
  assign axi_wready  = (w_state_reg == W_IDLE) && !w_got_reg;
  assign axi_bvalid  = (w_state_reg == W_RESP);
  assign axi_bresp   = {{(ISA_WIDTH-2){1'b0}}, bresp_reg};

endmodule
